// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding and default widths for ram_master / simple_ram
package ram_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_INIT    = 3'd4
  } state_e;

endpackage

// File: rtl/ts_buf.sv
// rtl/ts_buf.sv - tri-state buffer driving a shared bus
module ts_buf #(
  parameter int W = 8
) (
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  inout  wire  [W-1:0] bus_io
);

  assign bus_io = en_i ? data_i : {W{1'bz}};

endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - command-driven bus initiator for simple_ram
// Optional power-up zero sweep of the RAM enabled by RAM_MASTER_INIT_EN.
module ram_master
  import ram_pkg::*;
#(
  parameter int BYTE_W   = BYTE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_ADDR = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BYTE_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [BYTE_W-1:0] rsp_rdata,
  inout  wire  [BYTE_W-1:0] mem_bus,
  output logic [ADDR_W-1:0] address,
  output logic              r_e,
  output logic              w_e
);

`ifdef RAM_MASTER_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(NUM_ADDR - 1);
  logic [ADDR_W:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] wdata_q, wdata_d;
  logic [BYTE_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              r_e_q, r_e_d;
  logic              w_e_q, w_e_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              bus_oe;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    r_e_d       = 1'b0;
    w_e_d       = 1'b0;
    rsp_valid_d = 1'b0;
    cmd_ready   = 1'b0;
`ifdef RAM_MASTER_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr & ADDR_W'(NUM_ADDR - 1);
          wdata_d = cmd_wdata;
          if (cmd_we) begin
            state_d = ST_WR;
            w_e_d   = 1'b1;
          end else begin
            state_d = ST_RD_ADDR;
            r_e_d   = 1'b1;
          end
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
        r_e_d   = 1'b1;
      end
      ST_RD_DATA: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_bus;
      end
`ifdef RAM_MASTER_INIT_EN
      ST_INIT: begin
        // Output registers trail the counter by one cycle, so the last zero write lands in IDLE.
        addr_d     = init_cnt_q[ADDR_W-1:0];
        wdata_d    = '0;
        w_e_d      = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
      end
`endif
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      r_e_q       <= 1'b0;
      w_e_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef RAM_MASTER_INIT_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      r_e_q       <= r_e_d;
      w_e_q       <= w_e_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef RAM_MASTER_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  // Drive the bus exactly while a write strobe is presented; this covers WR and the init sweep.
  assign bus_oe = w_e_q;

  ts_buf #(.W(BYTE_W)) u_buf (
    .en_i   (bus_oe),
    .data_i (wdata_q),
    .bus_io (mem_bus)
  );

  assign address   = addr_q;
  assign r_e       = r_e_q;
  assign w_e       = w_e_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
